// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: Sysbus responder storing 8-word lines, answering reads
// with critical-word-first bursts that echo the request tag.
module sysbus_mem_responder #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int MEM_WORDS      = 4096,
   parameter int MEM_LATENCY    = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_reqack,
   output logic                      bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   input  logic                      bus_respack,
   output logic                      busy
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int LW = $clog2(MEM_LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_WR_DATA, S_RD_WAIT, S_RD_BURST} state_t;

   state_t                    r_state;
   logic [BUS_DATA_WIDTH-1:0] r_mem [MEM_WORDS];
   logic [AW-4:0]             r_line;
   logic [2:0]                r_start;
   logic [3:0]                r_beat;
   logic [LW-1:0]             r_lat;
   logic [BUS_TAG_WIDTH-1:0]  r_tag;
   logic                      w_accept;
   logic                      w_wr;
   logic [AW-1:0]             w_idx;
   logic [AW-1:0]             w_addr;
   logic                      w_unused;

   assign w_idx    = bus_req[AW+2:3];
   // beat offset wraps inside the line, never into the next one
   assign w_addr   = {r_line, r_start + r_beat[2:0]};
   assign w_accept = bus_reqcyc && !bus_reqack && (r_state == S_IDLE || r_state == S_WR_DATA);
   assign w_wr     = w_accept && r_state == S_WR_DATA;
   assign busy     = r_state != S_IDLE;
   assign w_unused = ^{bus_req[BUS_DATA_WIDTH-1:AW+3], bus_req[2:0]};

   always_ff @(posedge clk)
      if (w_wr) r_mem[w_addr] <= bus_req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         bus_reqack  <= 1'b0;
         bus_respcyc <= 1'b0;
         bus_resp    <= '0;
         bus_resptag <= '0;
         r_line      <= '0;
         r_start     <= '0;
         r_beat      <= '0;
         r_lat       <= '0;
         r_tag       <= '0;
      end else begin
         bus_reqack <= w_accept;
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_line  <= w_idx[AW-1:3];
               r_start <= w_idx[2:0];
               r_tag   <= bus_reqtag;
               r_beat  <= '0;
               r_lat   <= '0;
               r_state <= bus_reqtag[BUS_TAG_WIDTH-1] ? S_WR_DATA : S_RD_WAIT;
            end
            S_WR_DATA: if (w_accept) begin
               r_beat <= r_beat + 4'd1;
               if (r_beat == 4'd7) r_state <= S_IDLE;
            end
            S_RD_WAIT: if (r_lat == LW'(MEM_LATENCY)) begin
               bus_respcyc <= 1'b1;
               bus_resp    <= r_mem[w_addr];
               bus_resptag <= r_tag;
               r_beat      <= 4'd1;
               r_state     <= S_RD_BURST;
            end else begin
               r_lat <= r_lat + 1'b1;
            end
            S_RD_BURST: if (bus_respack) begin
               if (r_beat == 4'd8) begin
                  bus_respcyc <= 1'b0;
                  r_beat      <= '0;
                  r_state     <= S_IDLE;
               end else begin
                  bus_resp <= r_mem[w_addr];
                  r_beat   <= r_beat + 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: table vectors, corner sequences and random traffic
// checked against a word-array model of the responder.
module tb_sysbus_mem_responder;
   localparam int MW  = 4096;
   localparam int LAT = 4;

   logic        clk = 0;
   logic        reset = 0;
   logic        reqcyc = 0;
   logic [63:0] req = 0;
   logic [12:0] reqtag = 0;
   logic        respack = 0;
   logic        reqack, respcyc, busy;
   logic [63:0] resp;
   logic [12:0] resptag;

   sysbus_mem_responder #(.MEM_WORDS(MW), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .bus_reqcyc(reqcyc), .bus_req(req), .bus_reqtag(reqtag),
      .bus_reqack(reqack), .bus_respcyc(respcyc), .bus_resp(resp), .bus_resptag(resptag),
      .bus_respack(respack), .busy(busy));

   always #5 clk = ~clk;

   logic [63:0] model [MW];
   int          wlines[$];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [63:0] addr;
      logic [12:0] tag;
      int          sb;
      int          sn;
      logic [63:0] exp0;
   } vec_t;
   vec_t vec[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // word touched by beat i of a line request to byte address a
   function automatic int widx(input logic [63:0] a, input int i);
      int w;
      w = int'((a >> 3) % MW);
      return (w / 8) * 8 + (w % 8 + i) % 8;
   endfunction

   task automatic send(input logic [63:0] d, input logic [12:0] t);
      int n = 0;
      req = d; reqtag = t; reqcyc = 1;
      do begin @(negedge clk); n++; end while (!reqack && n < 50);
      chk("reqack", reqack, 1);
      reqcyc = 0;
   endtask

   task automatic write_line(input logic [63:0] a, input logic [11:0] id, input logic [63:0] d[8]);
      send(a, {1'b1, id});
      for (int i = 0; i < 8; i++) send(d[i], 13'h0);
      for (int i = 0; i < 8; i++) model[widx(a, i)] = d[i];
      wlines.push_back(widx(a, 0) / 8);
      chk("wr_busy", busy, 0);
      chk("wr_respcyc", respcyc, 0);
   endtask

   task automatic read_line(input logic [63:0] a, input logic [12:0] t, input int sb, input int sn,
                            input bit acked, input bit rnd, input bit pend,
                            input logic [63:0] pa, input logic [12:0] pt, output logic [63:0] first);
      int n = 0;
      int st;
      first = 'x;
      if (!acked) send(a, t);
      while (!respcyc && n < 20) begin @(negedge clk); n++; end
      chk("latency", n, LAT + 1);
      for (int i = 0; i < 8; i++) begin
         st = rnd ? int'($urandom_range(0, 2)) : (i == sb ? sn : 0);
         for (int j = 0; j <= st; j++) begin
            chk($sformatf("rd_cyc[%0d]", i), respcyc, 1);
            chk($sformatf("rd_data[%0d]", i), resp, model[widx(a, i)]);
            chk($sformatf("rd_tag[%0d]", i), resptag, t);
            if (i == 0 && j == 0) first = resp;
            if (pend) chk("no_ack_burst", reqack, 0);
            if (pend && i == 3 && j == 0) begin req = pa; reqtag = pt; reqcyc = 1; end
            respack = (j == st);
            @(negedge clk);
         end
      end
      respack = 0;
      chk("rd_end_cyc", respcyc, 0);
      chk("rd_end_busy", busy, 0);
      if (pend) begin
         chk("pend_ack_early", reqack, 0);
         @(negedge clk);
         chk("pend_ack", reqack, 1);
         reqcyc = 0;
      end
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [63:0] d[8];
      logic [63:0] f;
      logic [63:0] a;
      int          n;
      vec[0] = '{64'h1000, 13'h0005, -1, 0, 64'hA0};
      vec[1] = '{64'h1028, 13'h0123, -1, 0, 64'hA5};
      vec[2] = '{64'h1000, 13'h0200,  2, 3, 64'hA0};
      vec[3] = '{64'h1000 + MW * 8, 13'h0ABC, -1, 0, 64'hA0};
      vec[4] = '{64'h1038, 13'h0FFF,  0, 1, 64'hA7};
      vec[5] = '{64'h1007, 13'h0001,  7, 2, 64'hA0};

      repeat (3) @(negedge clk);
      chk("rst_reqack", reqack, 0);
      chk("rst_respcyc", respcyc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_resp", resp, 0);
      chk("rst_resptag", resptag, 0);
      reset = 1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) d[i] = 64'hA0 + 64'(i);
      write_line(64'h1000, 12'h001, d);

      for (int k = 0; k < 6; k++) begin
         read_line(vec[k].addr, vec[k].tag, vec[k].sb, vec[k].sn, 0, 0, 0, 0, 0, f);
         chk($sformatf("vec_first[%0d]", k), f, vec[k].exp0);
      end

      read_line(64'h1010, 13'h0033, -1, 0, 0, 0, 1, 64'h1020, 13'h0044, f);
      chk("pend_first_a", f, 64'hA2);
      read_line(64'h1020, 13'h0044, -1, 0, 1, 0, 0, 0, 0, f);
      chk("pend_first_b", f, 64'hA4);

      send(64'h1018, 13'h0077);
      n = 0;
      while (!respcyc && n < 20) begin @(negedge clk); n++; end
      for (int i = 0; i < 3; i++) begin respack = 1; @(negedge clk); end
      respack = 0;
      chk("pre_rst_resp", resp, 64'hA6);
      #2 reset = 0;
      #1;
      chk("arst_respcyc", respcyc, 0);
      chk("arst_reqack", reqack, 0);
      chk("arst_busy", busy, 0);
      chk("arst_resp", resp, 0);
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      read_line(64'h1018, 13'h0078, 4, 1, 0, 0, 0, 0, 0, f);
      chk("post_rst_first", f, 64'hA3);

      for (int r = 0; r < 30; r++) begin
         a = {$urandom, $urandom};
         if (r < 4 || $urandom_range(0, 2) == 0) begin
            a[14:6] = 9'($urandom_range(0, MW / 8 - 1));
            for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
            write_line(a, 12'($urandom), d);
         end else begin
            a[14:6] = 9'(wlines[$urandom_range(0, wlines.size() - 1)]);
            read_line(a, {1'b0, 12'($urandom)}, -1, 0, 0, 1, 0, 0, 0, f);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Responder end of the Sysbus request/response interface that the instruction and data caches drive as initiators.
- Accepts one line-sized read or write request at a time and stores lines in an internal word-addressed array.
- Read data returns as an 8-beat, critical-word-first burst with the request tag echoed.
- Used as the memory model behind the arbiter in simulation and as the template for the off-core memory controller.

Parameters:
BUS_DATA_WIDTH, 64, width of bus_req/bus_resp; fixed 64 (one word per beat)
BUS_TAG_WIDTH, 13, tag width; bit [12] = WRITE (1) / READ (0), bits [11:0] opaque id
MEM_WORDS, 4096, depth of backing array in 64-bit words; power of two, multiple of 8
MEM_LATENCY, 4, idle cycles between read address acknowledge and first response beat; >=1

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
bus_reqcyc  input  1  initiator has a valid request/data beat on bus_req
bus_req  input  64  request address (first beat) or write data (subsequent beats)
bus_reqtag  input  13  request tag, valid with the address beat
bus_reqack  output  1  one-cycle pulse acknowledging a sampled request beat
bus_respcyc  output  1  valid read response beat on bus_resp
bus_resp  output  64  read response data
bus_resptag  output  13  echoed tag of the read being answered
bus_respack  input  1  initiator consumes the current response beat
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): FSM->IDLE; bus_reqack, bus_respcyc, busy = 0; bus_resp, bus_resptag = 0; beat and latency counters = 0. Array contents are not cleared. Reset mid-burst abandons the transaction with no partial write rollback.
- Addressing:
  - word index = bus_req[3+log2(MEM_WORDS)-1:3]; higher bits ignored, so the index wraps modulo MEM_WORDS.
  - bus_req[2:0] ignored.
  - line base = index with low 3 bits cleared.
  - start offset s = index[2:0]; beat i (0..7) uses line base + ((s+i) mod 8). Ordering is critical-word-first and wraps within the line, never into the next line.
- Beat acceptance rule: a request beat is sampled on an edge where bus_reqcyc=1 and bus_reqack=0 and the FSM is in an accepting state (IDLE or WR_DATA). bus_reqack=1 for exactly the following cycle. bus_reqcyc is never sampled while bus_reqack=1, so the maximum rate is one beat per 2 cycles.
- FSM states:
  - IDLE -> latch address, tag, s. Go to WR_DATA if tag[12]=1, else RD_WAIT. Clear counters.
  - WR_DATA: each accepted beat writes the array at beat index i, then i++. After beat 8 is accepted -> IDLE, on the same edge as the 8th write. No response is issued for writes.
  - RD_WAIT: latency counter counts MEM_LATENCY cycles. Address sampled at edge E0 means the first beat is visible (bus_respcyc=1) in cycle E0+1+MEM_LATENCY -> RD_BURST.
  - RD_BURST: bus_respcyc, bus_resp, bus_resptag are registered and held stable until an edge with bus_respcyc=1 and bus_respack=1. On that edge present the next beat (respcyc stays 1, no bubble). After beat 8 is consumed, drop respcyc -> IDLE. bus_resptag = latched tag for all 8 beats.
- bus_reqcyc while in RD_WAIT or RD_BURST is ignored with no ack; the initiator holds it until IDLE.
- The first request can be accepted on the edge after the last response beat is consumed (back-to-back).
- A read after a write to the same line returns the written data (write is committed before any later read is sampled).
- bus_respack while bus_respcyc=0 is ignored.

Test Plan:
- Write line at 0x1000 (tag 0x1001, data 0xA0..0xA7), then read 0x1000 (tag 0x0005) -> 8 beats 0xA0..0xA7 in order, resptag=0x0005 each beat, first beat in cycle E0+5.
- Read 0x1028 (s=5) of the same line -> beats 0xA5,0xA6,0xA7,0xA0,0xA1,0xA2,0xA3,0xA4.
- respack held low 3 cycles on beat 2, otherwise high -> bus_resp and bus_resptag stable during the stall, no beat skipped or repeated, total 8 handshakes.
- Second reqcyc asserted during RD_BURST -> no reqack until the cycle after the final beat handshake; that request is then acked and served correctly.
- Address 0x1000 + MEM_WORDS*8 -> aliases to index 0x200, returns 0xA0.. data.
- Assert reset low after 3 of 8 read beats -> respcyc, reqack, busy = 0 immediately (asynchronously). After release, a new read completes normally.
